// File: rtl/hex_ascii_tx_serializer_if.sv
// Handshake bundle between the hex translator, the serializer and the UART TX byte port.
interface hex_ascii_tx_serializer_if #(
    parameter int NUM_CHARS = 4
);
    logic [NUM_CHARS*8-1:0] frame_in;
    logic                   frame_valid;
    logic                   frame_ready;
    logic [7:0]             tx_data;
    logic                   tx_valid;
    logic                   tx_ready;
    logic                   busy;
    logic                   frame_done;

    modport master (
        output frame_in, frame_valid, tx_ready,
        input  frame_ready, tx_data, tx_valid, busy, frame_done
    );

    modport slave (
        input  frame_in, frame_valid, tx_ready,
        output frame_ready, tx_data, tx_valid, busy, frame_done
    );
endinterface

// File: rtl/hex_ascii_tx_serializer.sv
// Latches one ASCII hex frame, emits it MS char first; APPEND_CRLF_EN appends CR LF.
// First byte valid 1 cycle after accept; one byte per cycle; frame_done 1 cycle after last transfer.
// tx_data/tx_valid hold while tx_ready is low; frame_ready only in IDLE, so frames wait upstream.
module hex_ascii_tx_serializer #(
    parameter int NUM_CHARS = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    hex_ascii_tx_serializer_if.slave        bus
);
    localparam int IW = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

`ifdef APPEND_CRLF_EN
    typedef enum logic [1:0] {IDLE, SEND, CR, LF} state_t;
`else
    typedef enum logic {IDLE, SEND} state_t;
`endif

    state_t                     state;
    logic [IW-1:0]              idx;
    logic [IW-1:0]              idx_nxt;
    logic [NUM_CHARS-1:0][7:0]  frame_q;
    logic [7:0]                 tx_data_q;
    logic                       tx_valid_q;
    logic                       frame_done_q;

    assign idx_nxt = idx - IW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            frame_q      <= '0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.frame_valid) begin
                        frame_q    <= bus.frame_in;
                        idx        <= IW'(NUM_CHARS - 1);
                        tx_data_q  <= bus.frame_in[NUM_CHARS*8-1 -: 8];
                        tx_valid_q <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (bus.tx_ready) begin
                        if (idx != '0) begin
                            idx       <= idx_nxt;
                            tx_data_q <= frame_q[idx_nxt];
                        end else begin
`ifdef APPEND_CRLF_EN
                            tx_data_q    <= 8'h0D;
                            state        <= CR;
`else
                            tx_valid_q   <= 1'b0;
                            frame_done_q <= 1'b1;
                            state        <= IDLE;
`endif
                        end
                    end
                end
`ifdef APPEND_CRLF_EN
                CR: begin
                    if (bus.tx_ready) begin
                        tx_data_q <= 8'h0A;
                        state     <= LF;
                    end
                end
                LF: begin
                    if (bus.tx_ready) begin
                        tx_valid_q   <= 1'b0;
                        frame_done_q <= 1'b1;
                        state        <= IDLE;
                    end
                end
`endif
                default: begin
                    tx_valid_q <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs come straight from registers; no input-to-output path.
    assign bus.frame_ready = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.frame_done  = frame_done_q;
endmodule
